// File: rtl/snax_simbacore_job_sequencer.sv
// Job FIFO and issue sequencer for SimbaCore: buffers layer configs and issues them
// one at a time, tracking each job via the core busy flag and counting completions.
module snax_simbacore_job_sequencer #(
   parameter int RegDataWidth = 32,
   parameter int NumCfgRegs   = 5,
   parameter int QueueDepth   = 4,
   parameter int StartTimeout = 16,
   parameter int CntW         = $clog2(QueueDepth + 1)
) (
   input  logic                                    clk_i,
   input  logic                                    rst_i,
   input  logic [NumCfgRegs-1:0][RegDataWidth-1:0] job_cfg_i,
   input  logic                                    job_valid_i,
   output logic                                    job_ready_o,
   input  logic                                    clear_i,
   output logic [NumCfgRegs-1:0][RegDataWidth-1:0] core_cfg_o,
   output logic                                    core_cfg_valid_o,
   input  logic                                    core_cfg_ready_i,
   input  logic                                    core_busy_i,
   output logic [RegDataWidth-1:0]                 jobs_done_o,
   output logic [RegDataWidth-1:0]                 busy_cycles_o,
   output logic [CntW-1:0]                         fifo_count_o,
   output logic                                    idle_o,
   output logic                                    irq_o
);

   localparam int PtrW = (QueueDepth > 1) ? $clog2(QueueDepth) : 1;
   localparam int ToW  = $clog2(StartTimeout + 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_START, S_RUN} state_t;

   logic [NumCfgRegs-1:0][RegDataWidth-1:0] r_mem [QueueDepth];
   logic [PtrW-1:0]         r_wr_ptr, r_rd_ptr;
   logic [CntW-1:0]         r_count;
   logic                    r_keep;
   state_t                  r_state;
   logic                    r_cfg_valid;
   logic [ToW-1:0]          r_to;
   logic [RegDataWidth-1:0] r_jobs_done, r_busy_cycles;
   logic                    r_irq;

   logic w_full, w_push, w_pop, w_fifo_empty;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      if (p == PtrW'(QueueDepth - 1)) return '0;
      return p + 1'b1;
   endfunction

   // r_keep reserves the head slot when a clear lands while that entry is being
   // offered, so it stays addressable and protected until the handshake completes.
   assign w_full       = (int'(r_count) + int'(r_keep)) >= QueueDepth;
   assign job_ready_o  = ~w_full & ~clear_i;
   assign w_push       = job_valid_i & job_ready_o;
   assign w_pop        = r_cfg_valid & core_cfg_ready_i;
   assign w_fifo_empty = (r_count == '0);

   assign core_cfg_o       = (!w_fifo_empty || r_keep) ? r_mem[r_rd_ptr] : '0;
   assign core_cfg_valid_o = r_cfg_valid;
   assign jobs_done_o      = r_jobs_done;
   assign busy_cycles_o    = r_busy_cycles;
   assign fifo_count_o     = r_count;
   assign idle_o           = (r_state == S_IDLE) && w_fifo_empty;
   assign irq_o            = r_irq;

   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wr_ptr] <= job_cfg_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_keep   <= 1'b0;
      end else if (clear_i) begin
         r_count <= '0;
         if (w_pop) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_wr_ptr <= ptr_inc(r_rd_ptr);
            r_keep   <= 1'b0;
         end else if (r_state == S_ISSUE) begin
            r_wr_ptr <= ptr_inc(r_rd_ptr);
            r_keep   <= 1'b1;
         end else begin
            r_wr_ptr <= r_rd_ptr;
            r_keep   <= 1'b0;
         end
      end else begin
         if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_pop) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_keep   <= 1'b0;
         end
         if (w_push && !(w_pop && !r_keep))      r_count <= r_count + 1'b1;
         else if (!w_push && w_pop && !r_keep)   r_count <= r_count - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state       <= S_IDLE;
         r_cfg_valid   <= 1'b0;
         r_to          <= '0;
         r_jobs_done   <= '0;
         r_busy_cycles <= '0;
         r_irq         <= 1'b0;
      end else begin
         r_irq <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (!w_fifo_empty && !clear_i) begin
                  r_state     <= S_ISSUE;
                  r_cfg_valid <= 1'b1;
               end
            end
            S_ISSUE: begin
               if (core_cfg_ready_i) begin
                  r_state     <= S_WAIT_START;
                  r_cfg_valid <= 1'b0;
                  r_to        <= '0;
               end
            end
            S_WAIT_START: begin
               // The cycle busy first rises counts as a busy cycle of this job.
               if (core_busy_i) begin
                  r_state       <= S_RUN;
                  r_busy_cycles <= r_busy_cycles + 1'b1;
               end else if (r_to == ToW'(StartTimeout - 1)) begin
                  r_state     <= S_IDLE;
                  r_jobs_done <= r_jobs_done + 1'b1;
                  r_irq       <= w_fifo_empty && !w_push;
               end else begin
                  r_to <= r_to + 1'b1;
               end
            end
            S_RUN: begin
               if (core_busy_i) begin
                  r_busy_cycles <= r_busy_cycles + 1'b1;
               end else begin
                  r_state     <= S_IDLE;
                  r_jobs_done <= r_jobs_done + 1'b1;
                  r_irq       <= w_fifo_empty && !w_push;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_cfg_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
